// File: rtl/beep_sequencer.sv
// Plays fixed 8-step tone patterns on a buzzer. The patterns are selected by
// five debounced, active-low front-panel keys.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   key   raw active-low keys; key[3:0] start pattern 0..3, key[4] stops playback
//   beep  buzzer drive (registered)
//   led   led[3:0] one-hot active pattern, led[4] busy (registered)
module beep_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned UNIT_CYCLES     = 5_000_000,
   parameter int unsigned GAP_CYCLES      = 500_000,
   parameter int unsigned TONE_SHIFT      = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] key,
   output logic       beep,
   output logic [4:0] led
);

   localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned DUR_MIN = $clog2(4 * UNIT_CYCLES);
   localparam int unsigned DUR_W   = (DUR_MIN < 25) ? 25 : DUR_MIN;
   localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

   // Key synchroniser, debouncer and press-pulse generator
   logic [4:0]      sync1, sync2, deb, press;
   logic [DB_W-1:0] db_cnt [5];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '1;
         sync2 <= '1;
         deb   <= '1;
         press <= '0;
         for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         for (int i = 0; i < 5; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               db_cnt[i] <= '0;
               deb[i]    <= sync2[i];
               press[i]  <= ~sync2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // Pattern ROM: returns {tone[2:0], dur[1:0]}
   function automatic logic [4:0] step_rom(input logic [1:0] p, input logic [2:0] s);
      logic [2:0] t;
      logic [1:0] d;
      case (p)
         2'd0: begin t = (s == 3'd7) ? 3'd0 : s + 3'd1; d = 2'd0; end
         2'd1: begin t = s[0] ? 3'd0 : 3'd5;           d = 2'd1; end
         2'd2: begin t = s[1] ? 3'd0 : 3'd7;           d = 2'd0; end
         default: begin t = s[0] ? 3'd0 : 3'd1;        d = 2'd3; end
      endcase
      return {t, d};
   endfunction

   // Tone table: half-period in cycles; tone 0 is a rest
   function automatic logic [15:0] half_period(input logic [2:0] t);
      case (t)
         3'd1:    return 16'(32'd47778 >> TONE_SHIFT);
         3'd2:    return 16'(32'd42566 >> TONE_SHIFT);
         3'd3:    return 16'(32'd37922 >> TONE_SHIFT);
         3'd4:    return 16'(32'd35793 >> TONE_SHIFT);
         3'd5:    return 16'(32'd31888 >> TONE_SHIFT);
         3'd6:    return 16'(32'd28409 >> TONE_SHIFT);
         3'd7:    return 16'(32'd25310 >> TONE_SHIFT);
         default: return 16'd0;
      endcase
   endfunction

   state_t           state, state_n;
   logic [1:0]       pat, pat_n;
   logic [2:0]       step, step_n;
   logic [DUR_W-1:0] dur_cnt, dur_n, dur_end;
   logic [15:0]      tone_cnt, tone_n, half;
   logic [GAP_W-1:0] gap_cnt, gap_n;
   logic             beep_n;
   logic [4:0]       led_n;
   logic [4:0]       cur;
   logic [1:0]       start_pat;

   assign cur     = step_rom(pat, step);
   assign half    = half_period(cur[4:2]);
   assign dur_end = DUR_W'((32'(cur[1:0]) + 32'd1) * UNIT_CYCLES - 32'd1);

   // Lowest-index start key wins
   always_comb begin
      start_pat = 2'd3;
      if      (press[0]) start_pat = 2'd0;
      else if (press[1]) start_pat = 2'd1;
      else if (press[2]) start_pat = 2'd2;
   end

   // State register and all outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pat      <= 2'd0;
         step     <= 3'd0;
         dur_cnt  <= '0;
         tone_cnt <= '0;
         gap_cnt  <= '0;
         beep     <= 1'b0;
         led      <= '0;
      end else begin
         state    <= state_n;
         pat      <= pat_n;
         step     <= step_n;
         dur_cnt  <= dur_n;
         tone_cnt <= tone_n;
         gap_cnt  <= gap_n;
         beep     <= beep_n;
         led      <= led_n;
      end
   end

   // Next-state and output logic; stop beats start, start beats sequencing
   always_comb begin
      state_n = state;
      pat_n   = pat;
      step_n  = step;
      dur_n   = dur_cnt;
      tone_n  = tone_cnt;
      gap_n   = gap_cnt;
      beep_n  = beep;
      if (press[4]) begin
         state_n = IDLE;
         step_n  = 3'd0;
         dur_n   = '0;
         tone_n  = '0;
         gap_n   = '0;
         beep_n  = 1'b0;
      end else if (|press[3:0]) begin
         state_n = NOTE;
         pat_n   = start_pat;
         step_n  = 3'd0;
         dur_n   = '0;
         tone_n  = '0;
         gap_n   = '0;
         beep_n  = 1'b0;
      end else begin
         case (state)
            IDLE: beep_n = 1'b0;
            NOTE: begin
               dur_n = dur_cnt + DUR_W'(1);
               if (cur[4:2] != 3'd0) begin
                  if (tone_cnt == half - 16'd1) begin
                     tone_n = '0;
                     beep_n = ~beep;
                  end else begin
                     tone_n = tone_cnt + 16'd1;
                  end
               end else begin
                  beep_n = 1'b0;
               end
               if (dur_cnt == dur_end) begin
                  state_n = GAP;
                  beep_n  = 1'b0;
                  tone_n  = '0;
                  dur_n   = '0;
               end
            end
            GAP: begin
               beep_n = 1'b0;
               if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                  gap_n = '0;
                  if (step == 3'd7) begin
                     state_n = IDLE;
                  end else begin
                     step_n  = step + 3'd1;
                     state_n = NOTE;
                  end
               end else begin
                  gap_n = gap_cnt + GAP_W'(1);
               end
            end
            default: state_n = IDLE;
         endcase
      end
      led_n = (state_n == IDLE) ? 5'b0 : {1'b1, 4'b0001 << pat_n};
   end

endmodule

// File: doc/beep_sequencer.md
Name: beep_sequencer

Overview:
- Controller that sequences the buzzer through fixed 8-step tone patterns selected by front-panel keys.
- Debounces the five active-low keys and holds a small pattern ROM and a 7-entry tone table.
- Times each note, the gap after it, and the tone half-period.
- Drives the buzzer pin directly and mirrors play status on the LEDs.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronised samples required before a key state is accepted.
- UNIT_CYCLES, 5_000_000, length of one duration unit in clk cycles (100 ms at 50 MHz).
- GAP_CYCLES, 500_000, silent cycles after every step.
- TONE_SHIFT, 0, right shift applied to tone-table half-periods; used to shorten simulation.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- key  in  5  raw active-low keys. key[3:0] start pattern 0..3; key[4] stops playback.
- beep  out  1  buzzer drive.
- led  out  5  led[3:0] one-hot active pattern; led[4] busy.

Behaviour:
- Reset:
  - beep=0, led=0, state=IDLE.
  - All counters = 0.
  - Debounced key state = all released (1).
- Key conditioning:
  - Each key passes through a 2-FF synchroniser.
  - The debounced state updates only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A press pulse lasts one cycle, on a debounced 1->0 transition. Releases produce no pulse.
- Tone table (half-period in cycles, before >>TONE_SHIFT):
  - 1=47778, 2=42566, 3=37922, 4=35793, 5=31888, 6=28409, 7=25310.
  - Index 0 = rest.
- Pattern ROM: 8 steps per pattern, each step (tone[2:0], dur[1:0]). A step lasts (dur+1)*UNIT_CYCLES.
  - P0: tones 1,2,3,4,5,6,7,0, all dur 0.
  - P1: tones 5,0,5,0,5,0,5,0, all dur 1.
  - P2: tones 7,7,0,0,7,7,0,0, all dur 0.
  - P3: tones 1,0,1,0,1,0,1,0, all dur 3.
- States:
  - IDLE: beep=0, led=0.
  - NOTE:
    - dur_cnt increments every cycle.
    - If tone!=0, tone_cnt increments; when tone_cnt==half-1, tone_cnt clears and beep toggles.
    - Rest steps (tone 0) hold beep=0.
    - When dur_cnt==(dur+1)*UNIT_CYCLES-1: go to GAP, beep=0, tone_cnt and dur_cnt clear.
  - GAP:
    - beep=0; gap_cnt counts to GAP_CYCLES-1.
    - Then: if step==7, go to IDLE; else step+1 and go to NOTE.
- Start:
  - A press pulse on key[k] (k<4) in any state loads pattern k, step=0, state=NOTE, clears all counters and sets beep=0 in that same cycle.
  - First beep rise occurs half cycles after entry.
  - A press during playback restarts playback from step 0.
- Simultaneous events:
  - Stop (key[4]) beats all starts and forces IDLE the next cycle.
  - Among start keys, the lowest index wins.
- Outputs:
  - led[3:0] = one-hot of the loaded pattern while state!=IDLE.
  - led[4] = (state!=IDLE).
  - All outputs are registered.
- Counter widths:
  - dur_cnt: 25 bits minimum, sized for 4*UNIT_CYCLES.
  - tone_cnt: 16 bits.
  - No wrap is reachable.
- Reset mid-playback returns to IDLE in the next cycle with beep=0.

Test Plan (DEBOUNCE_CYCLES=4, UNIT_CYCLES=1000, GAP_CYCLES=10, TONE_SHIFT=8, so tone1 half=186, tone5 half=124, tone7 half=98):
- Debounce: key[0] low for 3 cycles then high -> no start, led=0. Held low for 6 cycles -> exactly one start; led=5'b10001.
- P0 full run: press key[0] -> first beep toggle 186 cycles after entry; 8 steps of 1000+10 cycles; step 7 is silent; returns to IDLE with led=0 after 8080 cycles.
- P1 rest handling: press key[1] -> steps 0/2/4/6 toggle every 124 cycles for 2000 cycles; steps 1/3/5/7 keep beep=0 for 2000 cycles.
- Pre-emption: during P3 step 2, press key[2] -> next cycle led=5'b10100, step=0, beep=0, first toggle after 98 cycles.
- Stop priority: key[4] and key[1] pressed in the same debounce cycle during P0 -> IDLE, beep=0, led=0; no restart.
- Reset: assert rst mid-NOTE for 1 cycle -> beep=0, led=0 next cycle; a later key[3] press plays P3 from step 0.
